// File: rtl/mpu_pkg.sv
// mpu_pkg
//   Shared constants and types for the MPU datapath blocks (loaders, result
//   writer, determinant unit).
//   - MATRIX_BITS : width of the flattened 5x5 signed 8-bit matrix bus
//   - ELEM_BITS   : width of one matrix element
//   - MAX_DIM     : largest supported matrix dimension
//   - ROW_STRIDE  : element-index distance between rows on the flat bus
//   - IDX_BITS    : width of a row/column index or a captured size
//   - writer_state_t : result writer state encoding
package mpu_pkg;

  localparam int MAX_DIM     = 5;
  localparam int ELEM_BITS   = 8;
  localparam int MATRIX_BITS = ELEM_BITS * MAX_DIM * MAX_DIM;
  localparam int ROW_STRIDE  = 5;
  localparam int IDX_BITS    = $clog2(MAX_DIM + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } writer_state_t;

endpackage

// File: rtl/mpu_element_select.sv
// mpu_element_select
//   Combinational picker for one element of the flattened matrix bus.
//   Element k = ROW_STRIDE*row + col sits at bits [MATRIX_BITS-1-8k -: 8],
//   so element (0,0) is the most significant byte.
//   Ports:
//     matrix : flattened 5x5 matrix
//     row    : row index
//     col    : column index
//     elem   : selected element, 0 when row or col is out of range
module mpu_element_select
  import mpu_pkg::*;
(
  input  logic [MATRIX_BITS-1:0] matrix,
  input  logic [IDX_BITS-1:0]    row,
  input  logic [IDX_BITS-1:0]    col,
  output logic [ELEM_BITS-1:0]   elem
);

  // A compare per element keeps every part-select constant, and an
  // out-of-range index simply matches nothing and yields zero.
  always_comb begin
    elem = '0;
    for (int r = 0; r < MAX_DIM; r++) begin
      for (int c = 0; c < MAX_DIM; c++) begin
        if (row == IDX_BITS'(r) && col == IDX_BITS'(c)) begin
          elem = matrix[MATRIX_BITS - 1 - ELEM_BITS * (r * ROW_STRIDE + c) -: ELEM_BITS];
        end
      end
    end
  end

endmodule

// File: rtl/mpu_result_writer.sv
// mpu_result_writer
//   Write-back end of the MPU datapath. On start it captures a flattened
//   matrix, its active size n and a destination base address, then streams
//   the n x n elements in row-major order to the memory write port, one per
//   valid/ready handshake, and finishes with a one-cycle done pulse.
//   Ports:
//     clock, reset         : rising-edge clock, async active-high reset
//     start                : write-back request, only looked at in IDLE
//     matrix, size         : matrix to write and its active dimension (1..5)
//     base_addr            : address of element (0,0)
//     busy                 : transfer in progress (WRITE and DONE)
//     done, error          : end-of-transfer pulse; error marks an illegal size
//     mem_valid, mem_ready : write handshake
//     mem_addr, mem_data   : write address and element value
module mpu_result_writer #(
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_DIM    = 5
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [8*MAX_DIM*MAX_DIM-1:0] matrix,
  input  logic [7:0]                   size,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic                         mem_valid,
  input  logic                         mem_ready,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [7:0]                   mem_data
);

  import mpu_pkg::*;

  localparam logic [IDX_BITS-1:0] IDX_ONE = 1;

  writer_state_t state;

  logic [MATRIX_BITS-1:0] mat_q;
  logic [IDX_BITS-1:0]    size_q;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [IDX_BITS-1:0]    row_q;
  logic [IDX_BITS-1:0]    col_q;

  logic                   handshake;
  logic                   size_ok;
  logic                   last_col;
  logic                   last_elem;
  logic [IDX_BITS-1:0]    size_m1;
  logic [IDX_BITS-1:0]    next_row;
  logic [IDX_BITS-1:0]    next_col;
  logic [ADDR_WIDTH-1:0]  next_addr;
  logic [MATRIX_BITS-1:0] sel_matrix;
  logic [IDX_BITS-1:0]    sel_row;
  logic [IDX_BITS-1:0]    sel_col;
  logic [ELEM_BITS-1:0]   sel_elem;

  // Next element position and its address. The element selector looks at
  // the live input bus while idle (so the first element is registered
  // together with the capture) and at the captured copy afterwards. The
  // address arithmetic is truncated to ADDR_WIDTH, so it wraps silently.
  always_comb begin
    handshake = mem_valid & mem_ready;
    size_ok   = (size != 8'd0) && (size <= 8'(MAX_DIM));
    size_m1   = size_q - IDX_ONE;
    last_col  = (col_q == size_m1);
    last_elem = last_col && (row_q == size_m1);
    next_col  = last_col ? '0 : col_q + IDX_ONE;
    next_row  = last_col ? row_q + IDX_ONE : row_q;
    next_addr = base_q
              + ADDR_WIDTH'(next_row) * ADDR_WIDTH'(size_q)
              + ADDR_WIDTH'(next_col);
    if (state == ST_IDLE) begin
      sel_matrix = matrix;
      sel_row    = '0;
      sel_col    = '0;
    end else begin
      sel_matrix = mat_q;
      sel_row    = next_row;
      sel_col    = next_col;
    end
  end

  mpu_element_select u_select (
    .matrix (sel_matrix),
    .row    (sel_row),
    .col    (sel_col),
    .elem   (sel_elem)
  );

  // Writer FSM with registered outputs. Address and data for the following
  // element are loaded on each handshake, so they stay put while the memory
  // stalls. A start outside IDLE is dropped, not queued.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      mat_q     <= '0;
      size_q    <= '0;
      base_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done  <= 1'b0;
          error <= 1'b0;
          if (start) begin
            mat_q  <= matrix;
            size_q <= size[IDX_BITS-1:0];
            base_q <= base_addr;
            row_q  <= '0;
            col_q  <= '0;
            busy   <= 1'b1;
            if (size_ok) begin
              state     <= ST_WRITE;
              mem_valid <= 1'b1;
              mem_addr  <= base_addr;
              mem_data  <= sel_elem;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
              error <= 1'b1;
            end
          end
        end

        ST_WRITE: begin
          if (handshake) begin
            if (last_elem) begin
              state     <= ST_DONE;
              mem_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              row_q    <= next_row;
              col_q    <= next_col;
              mem_addr <= next_addr;
              mem_data <= sel_elem;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          error <= 1'b0;
        end

        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          error     <= 1'b0;
          mem_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_result_writer.sv
// tb_mpu_result_writer
//   Scoreboard bench for mpu_result_writer. Each start pushes the writes the
//   design should make (address, element value, and cycle when the memory is
//   always ready) plus the expected done/error pulse. A monitor on the
//   falling edge pops and compares whenever a handshake or done shows up.
module tb_mpu_result_writer;

  localparam int AW    = 16;
  localparam int MBITS = 200;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [MBITS-1:0] matrix;
  logic [7:0]       size;
  logic [AW-1:0]    base_addr;
  logic             busy;
  logic             done;
  logic             error;
  logic             mem_valid;
  logic             mem_ready = 1'b0;
  logic [AW-1:0]    mem_addr;
  logic [7:0]       mem_data;

  mpu_result_writer #(.ADDR_WIDTH(AW), .MAX_DIM(5)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .matrix    (matrix),
    .size      (size),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    int            cyc;
  } wr_t;

  typedef struct {
    logic err;
    int   cyc;
  } dn_t;

  wr_t writeQ[$];
  dn_t doneQ[$];

  int nCompared   = 0;
  int nMismatched = 0;
  int cyc         = 0;
  int hsCount     = 0;
  int doneCount   = 0;
  int readyMode   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Element k of the flat bus, element 0 being the top byte.
  function automatic logic [7:0] elemOf(input logic [MBITS-1:0] m, input int k);
    return 8'(m >> (8 * (24 - k)));
  endfunction

  function automatic logic [MBITS-1:0] randMatrix();
    logic [223:0] t;
    for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom;
    return t[MBITS-1:0];
  endfunction

  // Reference model: the dense row-major write list for an n x n transfer.
  task automatic pushExpected(input int n, input logic [AW-1:0] base, input logic [MBITS-1:0] m,
                              input bit timed, input int startCyc);
    wr_t w;
    dn_t d;
    if (n >= 1 && n <= 5) begin
      for (int r = 0; r < n; r++) begin
        for (int c = 0; c < n; c++) begin
          w.addr = AW'(int'(base) + r * n + c);
          w.data = elemOf(m, r * 5 + c);
          w.cyc  = timed ? startCyc + r * n + c + 1 : -1;
          writeQ.push_back(w);
        end
      end
      d.err = 1'b0;
      d.cyc = timed ? startCyc + n * n + 1 : -1;
    end else begin
      d.err = 1'b1;
      d.cyc = startCyc + 1;
    end
    doneQ.push_back(d);
  endtask

  // Cycle counter; cycle j of a transfer is startCyc + j.
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Memory ready driver: 0 = always ready, 1 = alternating, 2 = random.
  initial forever begin
    @(posedge clock);
    #1;
    case (readyMode)
      0:       mem_ready = 1'b1;
      1:       mem_ready = ~mem_ready;
      default: mem_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compares handshakes and done pulses against the scoreboard.
  initial begin
    wr_t           w;
    dn_t           d;
    bit            prevStall = 1'b0;
    bit            checkIdleNext = 1'b0;
    logic [AW-1:0] prevAddr = '0;
    logic [7:0]    prevData = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prevStall     = 1'b0;
        checkIdleNext = 1'b0;
      end else begin
        if (checkIdleNext) begin
          checkOutput("busy_after_done", busy, 1'b0);
          checkIdleNext = 1'b0;
        end
        if (prevStall) begin
          checkOutput("valid_held", mem_valid, 1'b1);
          checkOutput("addr_held", mem_addr, prevAddr);
          checkOutput("data_held", mem_data, prevData);
        end
        if (mem_valid) begin
          checkOutput("busy_in_write", busy, 1'b1);
          if (writeQ.size() == 0) begin
            checkOutput("unexpected_valid", mem_valid, 1'b0);
          end else if (mem_ready) begin
            w = writeQ.pop_front();
            checkOutput("write_addr", mem_addr, w.addr);
            checkOutput("write_data", mem_data, w.data);
            if (w.cyc >= 0) checkOutput("write_cycle", cyc, w.cyc);
            hsCount++;
          end
        end
        prevStall = mem_valid && !mem_ready;
        prevAddr  = mem_addr;
        prevData  = mem_data;
        if (error && !done) checkOutput("error_without_done", done, 1'b1);
        if (done) begin
          if (doneQ.size() == 0) begin
            checkOutput("unexpected_done", done, 1'b0);
          end else begin
            d = doneQ.pop_front();
            checkOutput("error_flag", error, d.err);
            if (d.cyc >= 0) checkOutput("done_cycle", cyc, d.cyc);
            checkOutput("busy_at_done", busy, 1'b1);
            checkOutput("valid_at_done", mem_valid, 1'b0);
            checkOutput("writes_left_at_done", writeQ.size(), 0);
          end
          doneCount++;
          checkIdleNext = 1'b1;
        end
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_done"}, done, 1'b0);
    checkOutput({tag, "_error"}, error, 1'b0);
    checkOutput({tag, "_valid"}, mem_valid, 1'b0);
    checkOutput({tag, "_addr"}, mem_addr, 0);
    checkOutput({tag, "_data"}, mem_data, 0);
  endtask

  // Issues one start in the current idle cycle (called just after a rising
  // edge). pokeAt > 0 pulses a second start in that cycle of the transfer;
  // abortAfter > 0 asserts reset once that many handshakes have been seen.
  task automatic applyStimulus(input int n, input logic [AW-1:0] base, input logic [MBITS-1:0] m,
                               input int mode, input int pokeAt, input int abortAfter);
    int startCyc;
    int doneBefore;
    int hsBefore;
    int waited;
    readyMode  = mode;
    start      = 1'b1;
    size       = 8'(n);
    base_addr  = base;
    matrix     = m;
    startCyc   = cyc;
    doneBefore = doneCount;
    hsBefore   = hsCount;
    pushExpected(n, base, m, (mode == 0), startCyc);
    @(posedge clock);
    #1;
    start     = 1'b0;
    matrix    = randMatrix();
    size      = 8'($urandom);
    base_addr = AW'($urandom);
    if (pokeAt > 0) begin
      repeat (pokeAt - 1) begin
        @(posedge clock);
        #1;
      end
      start  = 1'b1;
      size   = 8'd1;
      matrix = randMatrix();
      @(posedge clock);
      #1;
      start = 1'b0;
    end
    if (abortAfter > 0) begin
      waited = 0;
      while (hsCount < hsBefore + abortAfter && waited < 300) begin
        @(posedge clock);
        #1;
        waited++;
      end
      checkOutput("handshakes_before_abort", hsCount - hsBefore, abortAfter);
      reset = 1'b1;
      #1;
      checkAllZero("abort");
      writeQ.delete();
      doneQ.delete();
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
    end else begin
      waited = 0;
      while (doneCount == doneBefore && waited < 300) begin
        @(posedge clock);
        #1;
        waited++;
      end
      checkOutput("done_seen", doneCount - doneBefore, 1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, wanted completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [MBITS-1:0] m;
    reset     = 1'b1;
    start     = 1'b0;
    size      = 8'd0;
    base_addr = '0;
    matrix    = '0;
    repeat (2) @(posedge clock);
    #1;
    checkAllZero("reset");
    reset = 1'b0;
    @(posedge clock);
    #1;

    $display("[TB] reset mid-transfer");
    m = randMatrix();
    applyStimulus(3, 16'h0100, m, 0, 0, 4);
    applyStimulus(3, 16'h0100, m, 0, 0, 0);

    $display("[TB] full 5x5 stream");
    for (int k = 0; k < 25; k++) m[MBITS-1-8*k -: 8] = 8'(k + 1);
    applyStimulus(5, 16'h0000, m, 0, 0, 0);

    $display("[TB] partial 2x2 with backpressure");
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        m[MBITS-1-8*(5*r+c) -: 8] = 8'(10 * r + c);
    applyStimulus(2, 16'h0010, m, 1, 0, 0);

    $display("[TB] illegal sizes");
    applyStimulus(0, 16'h1234, randMatrix(), 0, 0, 0);
    applyStimulus(7, 16'h4321, randMatrix(), 0, 0, 0);

    $display("[TB] signed data and address wrap");
    m = {25{8'h80}};
    applyStimulus(2, 16'hFFFE, m, 0, 0, 0);

    $display("[TB] start while busy");
    applyStimulus(3, AW'($urandom), randMatrix(), 0, 4, 0);

    $display("[TB] randomized transfers");
    for (int i = 0; i < 25; i++) begin
      applyStimulus($urandom_range(0, 6), AW'($urandom), randMatrix(), $urandom_range(0, 2), 0, 0);
    end

    readyMode = 0;
    repeat (5) @(posedge clock);
    #1;
    checkOutput("pending_writes", writeQ.size(), 0);
    checkOutput("pending_dones", doneQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
